// File: rtl/dvi_out_fmt.sv
// DVI output formatter: reduces 8-bit colour to R_W/G_W/B_W by truncation, rounding or
// ordered dither, or replaces it with a colour-bar pattern, with a fixed two-cycle latency.
module dvi_out_fmt #(
  parameter int   R_W      = 5,
  parameter int   G_W      = 6,
  parameter int   B_W      = 5,
  parameter int   BAR_LOG2 = 7,
  parameter logic VS_ACT   = 1'b1
) (
  input  logic           odck_in,
  input  logic           rst,
  input  logic           vsync_in,
  input  logic           hsync_in,
  input  logic           de_in,
  input  logic [7:0]     pixel_r_in,
  input  logic [7:0]     pixel_g_in,
  input  logic [7:0]     pixel_b_in,
  input  logic [1:0]     mode_in,
  output logic           pixel_clk_o,
  output logic           vsync_o,
  output logic           hsync_o,
  output logic           de_o,
  output logic [R_W-1:0] pixel_r_o,
  output logic [G_W-1:0] pixel_g_o,
  output logic [B_W-1:0] pixel_b_o
);

  localparam int R_D = 8 - R_W;
  localparam int G_D = 8 - G_W;
  localparam int B_D = 8 - B_W;

  // Adds the mode-dependent offset, saturates at 255 and drops the d discarded bits.
  function automatic logic [7:0] fmt_ch(input logic [7:0] v, input int d,
                                        input logic [1:0] mode, input logic [1:0] t,
                                        input logic bar_on);
    logic [9:0] add;
    logic [9:0] sum;
    logic [7:0] sat;
    case (mode)
      2'd1:    add = (10'd1 << d) >> 1;
      2'd2:    add = ({8'd0, t} << d) >> 2;
      default: add = 10'd0;
    endcase
    if (mode == 2'd3) begin
      sum = bar_on ? 10'd255 : 10'd0;
    end else begin
      sum = {2'b00, v} + add;
    end
    sat = (sum > 10'd255) ? 8'd255 : sum[7:0];
    return sat >> d;
  endfunction

  logic        r_vs_prev, r_de_prev, r_frame;
  logic [11:0] r_x, r_y;
  logic [1:0]  r_mode;
  logic        r_s1_vs, r_s1_hs, r_s1_de;
  logic [7:0]  r_s1_r, r_s1_g, r_s1_b;
  logic [1:0]  r_s1_mode, r_s1_t;
  logic [2:0]  r_s1_bar;

  logic        w_vs_edge, w_de_fall;
  logic [11:0] w_x;
  logic [1:0]  w_t;

  assign pixel_clk_o = odck_in;
  assign w_vs_edge   = (vsync_in == VS_ACT) && (r_vs_prev != VS_ACT);
  assign w_de_fall   = r_de_prev && !de_in;
  assign w_x         = (de_in && r_de_prev) ? r_x + 12'd1 : 12'd0;

  // 2x2 ordered-dither threshold for the pixel now at the input.
  always_comb begin
    w_t = 2'd0;
    case ({r_y[0], w_x[0] ^ r_frame})
      2'b00:   w_t = 2'd0;
      2'b01:   w_t = 2'd2;
      2'b10:   w_t = 2'd3;
      2'b11:   w_t = 2'd1;
      default: w_t = 2'd0;
    endcase
  end

  // Raster position, frame parity and per-frame mode; a vsync edge beats a de fall for y.
  always_ff @(posedge odck_in) begin
    if (rst) begin
      r_vs_prev <= 1'b0;
      r_de_prev <= ~VS_ACT;
      r_x       <= 12'd0;
      r_y       <= 12'd0;
      r_frame   <= 1'b0;
      r_mode    <= 2'd0;
    end else begin
      r_vs_prev <= vsync_in;
      r_de_prev <= de_in;
      r_x       <= w_x;
      if (w_vs_edge) begin
        r_y     <= 12'd0;
        r_frame <= ~r_frame;
        r_mode  <= mode_in;
      end else if (w_de_fall) begin
        r_y     <= r_y + 12'd1;
      end else begin
        r_y     <= r_y;
      end
    end
  end

  // First pipeline stage: capture the pixel with everything needed to format it.
  always_ff @(posedge odck_in) begin
    if (rst) begin
      r_s1_vs   <= 1'b0;
      r_s1_hs   <= 1'b0;
      r_s1_de   <= 1'b0;
      r_s1_r    <= 8'd0;
      r_s1_g    <= 8'd0;
      r_s1_b    <= 8'd0;
      r_s1_mode <= 2'd0;
      r_s1_t    <= 2'd0;
      r_s1_bar  <= 3'd0;
    end else begin
      r_s1_vs   <= vsync_in;
      r_s1_hs   <= hsync_in;
      r_s1_de   <= de_in;
      r_s1_r    <= pixel_r_in;
      r_s1_g    <= pixel_g_in;
      r_s1_b    <= pixel_b_in;
      r_s1_mode <= r_mode;
      r_s1_t    <= w_t;
      r_s1_bar  <= w_x[BAR_LOG2+2 -: 3];
    end
  end

  // Second stage: formatted colour, blanked outside the active area.
  always_ff @(posedge odck_in) begin
    if (rst) begin
      vsync_o   <= 1'b0;
      hsync_o   <= 1'b0;
      de_o      <= 1'b0;
      pixel_r_o <= {R_W{1'b0}};
      pixel_g_o <= {G_W{1'b0}};
      pixel_b_o <= {B_W{1'b0}};
    end else begin
      vsync_o <= r_s1_vs;
      hsync_o <= r_s1_hs;
      de_o    <= r_s1_de;
      if (r_s1_de) begin
        pixel_r_o <= R_W'(fmt_ch(r_s1_r, R_D, r_s1_mode, r_s1_t, ~r_s1_bar[1]));
        pixel_g_o <= G_W'(fmt_ch(r_s1_g, G_D, r_s1_mode, r_s1_t, ~r_s1_bar[2]));
        pixel_b_o <= B_W'(fmt_ch(r_s1_b, B_D, r_s1_mode, r_s1_t, ~r_s1_bar[0]));
      end else begin
        pixel_r_o <= {R_W{1'b0}};
        pixel_g_o <= {G_W{1'b0}};
        pixel_b_o <= {B_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_dvi_out_fmt.sv
// Scoreboard bench for dvi_out_fmt at default parameters: each driven cycle queues its
// hand-computed output, and a monitor checks it two clocks later.
module tb_dvi_out_fmt;

  logic       odck_in = 1'b0;
  logic       rst, vsync_in, hsync_in, de_in;
  logic [7:0] pixel_r_in, pixel_g_in, pixel_b_in;
  logic [1:0] mode_in;
  logic       pixel_clk_o, vsync_o, hsync_o, de_o;
  logic [4:0] pixel_r_o;
  logic [5:0] pixel_g_o;
  logic [4:0] pixel_b_o;

  dvi_out_fmt dut (
    .odck_in(odck_in), .rst(rst), .vsync_in(vsync_in), .hsync_in(hsync_in), .de_in(de_in),
    .pixel_r_in(pixel_r_in), .pixel_g_in(pixel_g_in), .pixel_b_in(pixel_b_in),
    .mode_in(mode_in), .pixel_clk_o(pixel_clk_o), .vsync_o(vsync_o), .hsync_o(hsync_o),
    .de_o(de_o), .pixel_r_o(pixel_r_o), .pixel_g_o(pixel_g_o), .pixel_b_o(pixel_b_o)
  );

  always #5 odck_in = ~odck_in;

  typedef struct {
    int         due;
    logic       vs, hs, de;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  logic [1:0] mode_sel = 2'd0;

  logic [4:0] bar_r [8] = '{5'd31, 5'd31, 5'd0, 5'd0, 5'd31, 5'd31, 5'd0, 5'd0};
  logic [5:0] bar_g [8] = '{6'd63, 6'd63, 6'd63, 6'd63, 6'd0, 6'd0, 6'd0, 6'd0};
  logic [4:0] bar_b [8] = '{5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0, 5'd31, 5'd0};

  always @(posedge odck_in) cyc <= cyc + 1;

  // Drives one cycle of input; a reset cycle also kills the output still in flight.
  task automatic drive(input logic rs, input logic vs, input logic hs, input logic de,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [4:0] er, input logic [5:0] eg, input logic [4:0] eb);
    exp_t e;
    exp_t p;
    @(negedge odck_in);
    rst = rs; vsync_in = vs; hsync_in = hs; de_in = de;
    pixel_r_in = r; pixel_g_in = g; pixel_b_in = b; mode_in = mode_sel;
    if (rs && q.size() > 0) begin
      if (q[$].due == cyc + 1) begin
        p = q.pop_back();
        p.vs = 1'b0; p.hs = 1'b0; p.de = 1'b0; p.r = 5'd0; p.g = 6'd0; p.b = 5'd0;
        q.push_back(p);
      end
    end
    e.due = cyc + 2;
    e.vs  = rs ? 1'b0 : vs;
    e.hs  = rs ? 1'b0 : hs;
    e.de  = rs ? 1'b0 : de;
    e.r   = rs ? 5'd0 : er;
    e.g   = rs ? 6'd0 : eg;
    e.b   = rs ? 5'd0 : eb;
    q.push_back(e);
  endtask

  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                     input logic [4:0] er, input logic [5:0] eg, input logic [4:0] eb);
    drive(1'b0, 1'b0, 1'b0, 1'b1, r, g, b, er, eg, eb);
  endtask

  // Blanking cycle with deliberately nonzero colour on the inputs.
  task automatic gap(input logic vs, input logic hs);
    drive(1'b0, vs, hs, 1'b0, 8'hAA, 8'h55, 8'hC3, 5'd0, 6'd0, 5'd0);
  endtask

  // Monitor: compares whatever output is due this cycle.
  always @(negedge odck_in) begin : monitor
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      total++;
      if ({vsync_o, hsync_o, de_o, pixel_r_o, pixel_g_o, pixel_b_o} !==
          {e.vs, e.hs, e.de, e.r, e.g, e.b}) begin
        bad++;
        $display("FAIL out cyc=%0d got vs/hs/de=%b%b%b rgb=%0d/%0d/%0d want vs/hs/de=%b%b%b rgb=%0d/%0d/%0d",
                 cyc, vsync_o, hsync_o, de_o, pixel_r_o, pixel_g_o, pixel_b_o,
                 e.vs, e.hs, e.de, e.r, e.g, e.b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; vsync_in = 1'b0; hsync_in = 1'b0; de_in = 1'b0;
    pixel_r_in = 8'd0; pixel_g_in = 8'd0; pixel_b_in = 8'd0; mode_in = 2'd0;
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 5'd0, 6'd0, 5'd0);
    gap(1'b0, 1'b0);
    gap(1'b0, 1'b1);

    // truncate after reset
    pix(8'hFF, 8'h83, 8'h07, 5'd31, 6'd32, 5'd0);
    pix(8'h84, 8'h7F, 8'hF8, 5'd16, 6'd31, 5'd31);
    gap(1'b0, 1'b1);
    gap(1'b0, 1'b0);

    // round
    mode_sel = 2'd1;
    gap(1'b1, 1'b0);
    gap(1'b1, 1'b0);
    gap(1'b0, 1'b0);
    pix(8'hFE, 8'hFE, 8'h00, 5'd31, 6'd63, 5'd0);
    pix(8'h81, 8'h81, 8'h0C, 5'd16, 6'd32, 5'd2);
    pix(8'h82, 8'h82, 8'h0B, 5'd16, 6'd33, 5'd1);
    gap(1'b0, 1'b1);

    // dither, frame parity 0
    mode_sel = 2'd2;
    gap(1'b1, 1'b0);
    gap(1'b0, 1'b0);
    pix(8'h04, 8'h02, 8'h04, 5'd0, 6'd0, 5'd0);
    pix(8'h04, 8'h02, 8'h04, 5'd1, 6'd1, 5'd1);
    gap(1'b0, 1'b0);
    pix(8'h04, 8'h02, 8'h04, 5'd1, 6'd1, 5'd1);
    pix(8'h04, 8'h02, 8'h04, 5'd0, 6'd0, 5'd0);
    gap(1'b0, 1'b0);
    pix(8'h04, 8'h02, 8'h04, 5'd0, 6'd0, 5'd0);
    pix(8'h04, 8'h02, 8'h04, 5'd1, 6'd1, 5'd1);
    // vsync edge on the same cycle as de falls from line y=2
    gap(1'b1, 1'b0);
    gap(1'b0, 1'b0);
    // frame parity 1: x phase inverted, y restarted at 0
    pix(8'h04, 8'h02, 8'h04, 5'd1, 6'd1, 5'd1);
    pix(8'h04, 8'h02, 8'h04, 5'd0, 6'd0, 5'd0);
    gap(1'b0, 1'b0);
    pix(8'h04, 8'h02, 8'h04, 5'd0, 6'd0, 5'd0);
    pix(8'h04, 8'h02, 8'h04, 5'd1, 6'd1, 5'd1);
    gap(1'b0, 1'b0);

    // mode request changes mid-frame: still dithered
    mode_sel = 2'd3;
    pix(8'h04, 8'h02, 8'h04, 5'd1, 6'd1, 5'd1);
    gap(1'b0, 1'b0);

    // colour bars from the next frame
    gap(1'b1, 1'b0);
    gap(1'b0, 1'b0);
    for (int x = 0; x < 1024; x++) begin
      pix(8'h5A, 8'h5A, 8'h5A, bar_r[x >> 7], bar_g[x >> 7], bar_b[x >> 7]);
    end
    gap(1'b0, 1'b1);

    // reset pulse mid-line
    pix(8'h5A, 8'h5A, 8'h5A, 5'd31, 6'd63, 5'd31);
    pix(8'h5A, 8'h5A, 8'h5A, 5'd31, 6'd63, 5'd31);
    pix(8'h5A, 8'h5A, 8'h5A, 5'd31, 6'd63, 5'd31);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h5A, 8'h5A, 5'd0, 6'd0, 5'd0);
    gap(1'b0, 1'b0);
    pix(8'hFF, 8'h83, 8'h07, 5'd31, 6'd32, 5'd0);
    gap(1'b0, 1'b0);
    gap(1'b1, 1'b0);
    gap(1'b0, 1'b0);
    pix(8'h00, 8'h00, 8'h00, 5'd31, 6'd63, 5'd31);
    pix(8'h00, 8'h00, 8'h00, 5'd31, 6'd63, 5'd31);
    gap(1'b0, 1'b0);
    gap(1'b0, 1'b0);

    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge odck_in);
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dvi_out_fmt.md
DVI_OUT_FMT -- requirements
Module: dvi_out_fmt

Interface
REQ-001 Parameter R_W, default 5: red output width, legal 1..8.
REQ-002 Parameter G_W, default 6: green output width, legal 1..8.
REQ-003 Parameter B_W, default 5: blue output width, legal 1..8.
REQ-004 Parameter BAR_LOG2, default 7: log2 of test-pattern bar width in pixels, legal 0..8.
REQ-005 Parameter VS_ACT, default 1: active level of vsync_in, used for frame-edge detection.
REQ-006 odck_in  input  1  pixel clock; the only clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 vsync_in / hsync_in / de_in  input  1 each  timing-generator sync and data-enable.
REQ-009 pixel_r_in / pixel_g_in / pixel_b_in  input  8 each  source colour.
REQ-010 mode_in  input  2  requested mode: 0 truncate, 1 round, 2 dither, 3 colour-bar test pattern.
REQ-011 pixel_clk_o  output  1  equal to odck_in, combinational, unregistered.
REQ-012 vsync_o / hsync_o / de_o  output  1 each  sync and enable delayed to match pixel latency.
REQ-013 pixel_r_o / pixel_g_o / pixel_b_o  output  R_W / G_W / B_W  formatted colour.

Function
REQ-014 Fixed latency of 2 odck_in cycles from every input to its corresponding output, all modes; vsync_o, hsync_o, de_o SHALL be the inputs delayed by exactly 2 cycles.
REQ-015 Per channel, D = 8 - channel width discarded bits; D = 0 SHALL pass the 8-bit value unchanged in modes 0-2.
REQ-016 Mode 0: output = input[7:D].
REQ-017 Mode 1: output = min(input + 2^(D-1), 255)[7:D]; saturation at 255, no wrap.
REQ-018 Mode 2: output = min(input + off, 255)[7:D], off = (t << D) >> 2, t from 2x2 matrix indexed {y[0], x[0] XOR frame}: 00->0, 01->2, 10->3, 11->1.
REQ-019 Mode 3: colour ignored; bar = x[BAR_LOG2+2:BAR_LOG2]; bars 0..7 = white, yellow, cyan, green, magenta, red, blue, black at 8-bit full scale (255/0), then truncated as mode 0.
REQ-020 Pixel outputs SHALL be 0 on any cycle where de_o is 0, all modes.
REQ-021 x counter (12 bit): 0 on first de_in-high cycle of a line, +1 per subsequent de_in-high cycle, cleared while de_in low; wraps at 4095.
REQ-022 y counter (12 bit): +1 on each de_in 1->0 transition, cleared on vsync active edge (vsync_in transitions to VS_ACT); wraps at 4095.
REQ-023 frame bit toggles on each vsync active edge.
REQ-024 Active mode register loads mode_in only on vsync active edge; mode_in changes mid-frame SHALL not affect output until next frame.
REQ-025 Simultaneous vsync active edge and de_in falling edge: y clears (clear wins).
REQ-026 Edge detection uses a registered copy of previous vsync_in and de_in; the first cycle after reset sees previous values of 0 and (VS_ACT inverted) respectively.

Reset
REQ-027 While rst high at a clock edge: all registered outputs, pipeline stages, x, y, frame and active mode SHALL become 0; pixel_clk_o unaffected.
REQ-028 Reset asserted mid-line SHALL flush the pipeline; outputs SHALL be 0 from the first edge with rst high until 2 cycles after valid input resumes post-release.
REQ-029 After reset active mode is 0 (truncate) until the first vsync active edge.

Verification
REQ-030 Defaults, mode 0, de=1, r/g/b = 0xFF/0x83/0x07 -> 2 cycles later r/g/b_o = 31/32/0, syncs aligned.
REQ-031 Mode 1, G_W=6, g=0xFE -> 63 (saturated); g=0x81 -> 32; g=0x82 -> 33.
REQ-032 Mode 2, R_W=5, r=0x04 constant, 2x2 block over two frames -> outputs 0/1/1/0 pattern (off 0,4,6,2 at D=3) with x-phase inverting on the next frame.
REQ-033 mode_in 0->3 mid-frame -> no change until next vsync active edge; then bars of 128 px: x=0 white (31/63/31), x=128 yellow, x=896 black.
REQ-034 rst pulsed 1 cycle mid-line -> all outputs 0 next cycle, mode reverts to 0, x restarts at 0 on next de line.
REQ-035 de_in low with nonzero colour in every mode -> pixel outputs 0, de_o 0.
